// File: rtl/yoda_crypt_pkg.sv
// Shared constants, FSM state type and rotate helper for the yoda crypt datapath.
package yoda_crypt_pkg;

  localparam int unsigned YC_WIDTH     = 32;
  localparam int unsigned YC_ROT_WIDTH = 5;
  localparam logic [63:0] ADV_MODULUS  = 64'd4294967311;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IN,
    ST_KEYGEN,
    ST_SEND,
    ST_ACK
  } state_e;

  // Rotate through a doubled word so amt=0 never turns into a shift by the full width.
  function automatic logic [YC_WIDTH-1:0] rotl(input logic [YC_WIDTH-1:0]     word,
                                                input logic [YC_ROT_WIDTH-1:0] amt);
    logic [2*YC_WIDTH-1:0] dbl;
    dbl = {word, word} << amt;
    return dbl[2*YC_WIDTH-1 -: YC_WIDTH];
  endfunction

endpackage

// File: rtl/keystream_gen.sv
// Keystream generator shared by encrypter and decrypter: rotate-only, or the
// two-stage ADV pipeline (rotated square, then reduction mod ADV_MODULUS).
module keystream_gen #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ROT_WIDTH = 5,
  parameter bit          ADV       = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     key_i,
  input  logic [ROT_WIDTH-1:0] rot_i,
  input  logic                 start_i,
  output logic [WIDTH-1:0]     ks_o,
  output logic                 ks_valid_o
);
  import yoda_crypt_pkg::*;

  logic [WIDTH-1:0] ks_q, ks_d;
  logic             valid_q;

  generate
    if (ADV) begin : g_adv
      logic [ROT_WIDTH-1:0] x;
      logic [WIDTH-1:0]     k1, k2;
      logic [2*WIDTH-1:0]   sq_q, sq_d;
      logic                 v1_q;

      always_comb begin
        x  = key_i[ROT_WIDTH-1:0] ^ rot_i;
        k1 = key_i;
        k1[WIDTH-1 -: ROT_WIDTH] = key_i[WIDTH-1 -: ROT_WIDTH] ^ x;
        k2 = rotl(k1, x);
        sq_d = {{WIDTH{1'b0}}, k2} * {{WIDTH{1'b0}}, k2};
        // Residue can exceed 2^32; only the low word is kept, matching the encrypter.
        ks_d = WIDTH'(sq_q % ADV_MODULUS);
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sq_q    <= '0;
          v1_q    <= 1'b0;
          ks_q    <= '0;
          valid_q <= 1'b0;
        end else begin
          v1_q    <= start_i;
          valid_q <= v1_q;
          if (start_i) sq_q <= sq_d;
          if (v1_q)    ks_q <= ks_d;
        end
      end
    end else begin : g_basic
      always_comb ks_d = rotl(key_i, rot_i);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          ks_q    <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= start_i;
          if (start_i) ks_q <= ks_d;
        end
      end
    end
  endgenerate

  assign ks_o       = ks_q;
  assign ks_valid_o = valid_q;

endmodule

// File: rtl/decrypter.sv
// Decrypter: takes key/ciphertext from the parallelizer, xors with the keystream
// and hands plaintext to the collector over a four-phase handshake.
module decrypter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ROT_WIDTH = 5,
  parameter bit          ADV       = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in_p,
  input  logic [ROT_WIDTH-1:0] key_rotation_p,
  input  logic                 prog_p,
  input  logic                 data_ready_in_p,
  output logic                 ready_p,
  output logic [WIDTH-1:0]     data_out_c,
  output logic                 data_ready_out_c,
  input  logic                 capture_c
);
  import yoda_crypt_pkg::*;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     key_q, key_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [ROT_WIDTH-1:0] rot_q, rot_d;
  logic                 ready_q, ready_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 dro_q, dro_d;
  logic                 start_q, start_d;
  logic [WIDTH-1:0]     ks;
  logic                 ks_valid;

  keystream_gen #(
    .WIDTH    (WIDTH),
    .ROT_WIDTH(ROT_WIDTH),
    .ADV      (ADV)
  ) u_ksgen (
    .clk_i     (clk),
    .rst_i     (reset),
    .key_i     (key_q),
    .rot_i     (rot_q),
    .start_i   (start_q),
    .ks_o      (ks),
    .ks_valid_o(ks_valid)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    data_d  = data_q;
    rot_d   = rot_q;
    ready_d = ready_q;
    out_d   = out_q;
    dro_d   = dro_q;
    start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (prog_p) begin
          key_d   = data_in_p;
          ready_d = 1'b1;
          state_d = ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        if (prog_p) begin
          key_d = data_in_p;
        end else if (data_ready_in_p) begin
          data_d  = data_in_p;
          rot_d   = key_rotation_p;
          ready_d = 1'b0;
          start_d = 1'b1;
          state_d = ST_KEYGEN;
        end
      end
      // Leave KEYGEN on the generator's valid pulse so both keystream modes share one path.
      ST_KEYGEN: begin
        if (ks_valid) begin
          out_d   = data_q ^ ks;
          dro_d   = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (capture_c) begin
          dro_d   = 1'b0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!capture_c) begin
          ready_d = 1'b1;
          state_d = ST_WAIT_IN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
        dro_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      data_q  <= '0;
      rot_q   <= '0;
      ready_q <= 1'b0;
      out_q   <= '0;
      dro_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      data_q  <= data_d;
      rot_q   <= rot_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      dro_q   <= dro_d;
      start_q <= start_d;
    end
  end

  assign ready_p          = ready_q;
  assign data_out_c       = out_q;
  assign data_ready_out_c = dro_q;

endmodule

// File: tb/tb_decrypter.sv
// Directed bench for decrypter: a rotate-only and an ADV instance share stimulus.
module tb_decrypter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [4:0]  key_rot;
  logic        prog;
  logic        dri;
  logic        capture;

  logic        rdy0, dro0, rdy1, dro1;
  logic [31:0] out0, out1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decrypter #(.WIDTH(32), .ROT_WIDTH(5), .ADV(1'b0)) dut0 (
    .clk             (clk),
    .reset           (reset),
    .data_in_p       (data_in),
    .key_rotation_p  (key_rot),
    .prog_p          (prog),
    .data_ready_in_p (dri),
    .ready_p         (rdy0),
    .data_out_c      (out0),
    .data_ready_out_c(dro0),
    .capture_c       (capture)
  );

  decrypter #(.WIDTH(32), .ROT_WIDTH(5), .ADV(1'b1)) dut1 (
    .clk             (clk),
    .reset           (reset),
    .data_in_p       (data_in),
    .key_rotation_p  (key_rot),
    .prog_p          (prog),
    .data_ready_in_p (dri),
    .ready_p         (rdy1),
    .data_out_c      (out1),
    .data_ready_out_c(dro1),
    .capture_c       (capture)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rotl(input logic [31:0] w, input logic [4:0] a);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < int'(a); i++) v = {v[30:0], v[31]};
    return v;
  endfunction

  function automatic logic [31:0] ref_adv(input logic [31:0] key, input logic [4:0] r);
    logic [4:0]  x;
    logic [31:0] k1, k2;
    logic [63:0] k3, m;
    x  = key[4:0] ^ r;
    k1 = key ^ ({27'd0, x} << 27);
    k2 = ref_rotl(k1, x);
    k3 = {32'd0, k2} * {32'd0, k2};
    m  = k3 % 64'd4294967311;
    return m[31:0];
  endfunction

  task automatic program_key(input logic [31:0] k);
    prog    = 1'b1;
    data_in = k;
    @(negedge clk);
    prog    = 1'b0;
  endtask

  // Presents one ciphertext word and waits (bounded) until both instances show plaintext.
  task automatic issue(input logic [31:0] c, input logic [4:0] r,
                       input logic [31:0] e0, input logic [31:0] e1, input string tag);
    int c0 = -1;
    int c1 = -1;
    data_in = c;
    key_rot = r;
    dri     = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        dri = 1'b0;
        check({tag, "_rdy_low"}, {31'd0, rdy0}, 32'd0);
      end
      if (dro0 && c0 < 0) c0 = n;
      if (dro1 && c1 < 0) c1 = n;
      if (c0 >= 0 && c1 >= 0) break;
    end
    check({tag, "_lat0"}, 32'(c0 - 1), 32'd2);
    check({tag, "_lat1"}, 32'(c1 - 1), 32'd3);
    check({tag, "_out0"}, out0, e0);
    check({tag, "_out1"}, out1, e1);
  endtask

  task automatic ack(input string tag);
    capture = 1'b1;
    @(negedge clk);
    check({tag, "_dro_clr"}, {30'd0, dro1, dro0}, 32'd0);
    capture = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_back"}, {30'd0, rdy1, rdy0}, 32'd3);
  endtask

  task automatic xfer(input logic [31:0] key, input logic [31:0] c, input logic [4:0] r,
                      input logic [31:0] e0, input string tag);
    issue(c, r, e0, c ^ ref_adv(key, r), tag);
    ack(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] k, p, c, e0, e1;
    logic [4:0]  r;

    reset = 1'b1; data_in = '0; key_rot = '0; prog = 1'b0; dri = 1'b0; capture = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rdy", {30'd0, rdy1, rdy0}, 32'd0);
    check("rst_dro", {30'd0, dro1, dro0}, 32'd0);
    check("rst_out0", out0, 32'd0);
    check("rst_out1", out1, 32'd0);

    // Basic known-answer vectors
    program_key(32'h12345678);
    check("prog_rdy", {30'd0, rdy1, rdy0}, 32'd3);
    xfer(32'h12345678, 32'hFDE8D96E, 5'd4, 32'hDEADBEEF, "kat1");
    program_key(32'hA5A5A5A5);
    xfer(32'hA5A5A5A5, 32'h5A5A5A5A, 5'd0, 32'hFFFFFFFF, "kat_r0");
    program_key(32'h00000001);
    xfer(32'h00000001, 32'h80000001, 5'd31, 32'h00000001, "kat_r31");

    // Collector stalls, then holds capture high through ACK
    k = 32'h0F1E2D3C; c = 32'h13579BDF; r = 5'd9;
    program_key(k);
    e0 = c ^ ref_rotl(k, r);
    e1 = c ^ ref_adv(k, r);
    issue(c, r, e0, e1, "hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out0", out0, e0);
      check("hold_out1", out1, e1);
      check("hold_flags", {29'd0, dro0, dro1, rdy0}, 32'd6);
    end
    capture = 1'b1;
    @(negedge clk);
    check("ackh_dro", {30'd0, dro1, dro0}, 32'd0);
    check("ackh_out0", out0, e0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ackh_rdy", {30'd0, rdy1, rdy0}, 32'd0);
    end
    capture = 1'b0;
    @(negedge clk);
    check("ackh_rdy_back", {30'd0, rdy1, rdy0}, 32'd3);

    // Key load beats a simultaneous data word
    prog = 1'b1; dri = 1'b1; data_in = 32'hCAFEBABE; key_rot = 5'd3;
    @(negedge clk);
    prog = 1'b0; dri = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("both_noout", {30'd0, dro1, dro0}, 32'd0);
      check("both_rdy", {30'd0, rdy1, rdy0}, 32'd3);
    end
    c = 32'h11223344;
    xfer(32'hCAFEBABE, c, 5'd7, c ^ ref_rotl(32'hCAFEBABE, 5'd7), "newkey");

    // Random round-trip: ciphertext from the encrypter model
    for (int i = 0; i < 1000; i++) begin
      k = $urandom;
      r = 5'($urandom_range(0, 31));
      p = $urandom;
      program_key(k);
      c = p ^ ref_adv(k, r);
      issue(c, r, c ^ ref_rotl(k, r), p, "adv");
      ack("adv");
    end

    // Asynchronous reset while presenting plaintext
    program_key(32'h76543210);
    c = 32'hA1B2C3D4;
    issue(c, 5'd17, c ^ ref_rotl(32'h76543210, 5'd17), c ^ ref_adv(32'h76543210, 5'd17), "mid");
    #2 reset = 1'b1;
    #1;
    check("arst_flags", {29'd0, rdy0, dro1, dro0}, 32'd0);
    check("arst_out0", out0, 32'd0);
    check("arst_out1", out1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dri = 1'b1; data_in = 32'h55AA55AA; key_rot = 5'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("nokey_flags", {28'd0, rdy1, rdy0, dro1, dro0}, 32'd0);
    end
    dri = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
